rebote_ocho_botones: RTL and testbench
======================================

# rebote_ocho_botones

Synchronizes and debounces eight asynchronous push-button/switch inputs and presents a clean, registered 8-bit level vector to the 8-to-4 encoder stage directly downstream. It also emits one-cycle rising-edge and change strobes so later sequential logic can react once per press instead of once per clock.

## Interface

Parameters:
- `DIV`, 100000, prescaler period in clock cycles between debounce sample ticks (1 ms at 100 MHz); legal range ≥ 2.
- `STABLE`, 4, number of consecutive sample ticks a new input value must persist before it is accepted; legal range ≥ 1.

Ports:
- `clk`  input  1  single system clock; all state updates on rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `btn`  input  8  raw asynchronous button levels, bit i = button i.
- `ocho`  output  8  debounced level vector, registered; feeds the 8-to-4 encoder.
- `flanco`  output  8  bit i pulses high for exactly one cycle when `ocho[i]` goes 0→1.
- `cambio`  output  1  one-cycle pulse when any bit of `ocho` changes in either direction.

## Operation

- Input synchronizer: two flip-flops per bit; `s[i]` is `btn[i]` delayed 2 cycles. There is no combinational path from `btn` to any output.
- Prescaler:
  - Counter `pre` counts 0..DIV-1 and wraps.
  - `tick` is high in the cycle where `pre == DIV-1`.
  - The counter is free-running and is not restarted by input activity.
- Per-bit debounce, evaluated only on `tick`. Each bit has counter `cnt[i]` of width clog2(STABLE) (minimum 1).
  - `s[i] == ocho[i]`: `cnt[i] <= 0`.
  - `s[i] != ocho[i]` and `cnt[i] == STABLE-1`: `ocho[i] <= s[i]`, `cnt[i] <= 0`.
  - `s[i] != ocho[i]` otherwise: `cnt[i] <= cnt[i] + 1`.
  - Any agreeing tick restarts the count, so a glitch shorter than STABLE ticks never reaches `ocho`.
  - `cnt` never exceeds STABLE-1; there is no wrap-around.
- Strobes:
  - `flanco[i]` is registered and is high in the same cycle that `ocho[i]` first reads 1; it is low otherwise.
  - `cambio` is high in the same cycle that `ocho` first differs from its previous value.
  - Release (1→0) asserts `cambio` but not `flanco`.
- Simultaneous events: bits are independent. Several bits accepted on the same tick update `ocho` together, and their `flanco` bits assert together in one cycle with a single `cambio` pulse.
- Per-bit states are implicit: STABLE_LEVEL (`cnt == 0`, agree) and COUNTING (`0 < cnt < STABLE`, disagree). COUNTING returns to STABLE_LEVEL either on acceptance or on an agreeing tick.

## Timing

- Reset values: `ocho = 8'h00`, `flanco = 8'h00`, `cambio = 0`. Synchronizer flops, `cnt`, and `pre` are all 0.
- Reset asserted mid-count discards every partial count and the prescaler phase. After `rst` deasserts, the first `tick` occurs DIV cycles later.
- Acceptance latency for a `btn` change held clean from cycle t:
  - Minimum: 2 + (STABLE-1)·DIV + 1 cycles.
  - Maximum: 2 + STABLE·DIV cycles.
  - With DIV=4 and STABLE=3, `ocho` updates between cycle t+11 and cycle t+14.
- `ocho`, `flanco`, and `cambio` change only on the cycle following a `tick`. Back-to-back strobes are therefore at least DIV cycles apart.
- Throughput: the block accepts at most one level change per bit per STABLE ticks.

## Structure

- Shared package `lab_pkg`:
  - `N_BOTONES = 8`.
  - Default `DIV` and `STABLE` constants.
  - A clog2-based counter-width function.
- Natural sub-module: `rebote_bit`, one debouncer bit containing the 2-flop synchronizer, the `cnt` counter, the level register, and the edge register. It takes shared `tick` as an input.
- The top level holds the single prescaler and a generate loop of 8 `rebote_bit` instances. `cambio` is the OR of the per-bit change flags.

## Test plan

All scenarios use DIV=4 and STABLE=3.

- Reset: hold `rst` for 3 cycles with `btn = 8'hFF` → `ocho = 00`, `flanco = 00`, `cambio = 0` during reset and for at least 11 cycles after release. The code then reaches `ocho = FF`.
- Single press: `btn` goes 00→01 and is held → within 11–14 cycles `ocho = 01`. `flanco = 01` and `cambio = 1` for exactly one cycle; afterwards both return to 0 and `ocho` stays 01.
- Glitch rejection: with `ocho = 00`, pulse `btn[3]` high for 6 cycles (≤ 2 ticks) → `ocho`, `flanco`, and `cambio` stay 0 throughout.
- Simultaneous press then release:
  - `btn` goes 00→48 → `ocho = 48`, `flanco = 48`, and `cambio = 1` all in the same single cycle.
  - `btn` then goes 48→00 → `ocho = 00`, `flanco = 00`, and `cambio` pulses once.
- Reset mid-count: drive `btn = 40`, then assert `rst` for 1 cycle after 2 ticks → `ocho` remains 00, and acceptance of `40` requires a full fresh 3 ticks measured from reset release.
- All buttons: `btn = FF` from `ocho = 00` → `ocho = FF`, `flanco = FF` for one cycle, and `cambio` pulses once.

Source files
------------

// File: rtl/lab_pkg.sv
// rtl/lab_pkg.sv - shared constants and counter-width helper for the button front end
package lab_pkg;

  localparam int N_BOTONES  = 8;
  localparam int DIV_DEF    = 100000;
  localparam int STABLE_DEF = 4;

  // Counter width for a modulus of n, never narrower than one bit.
  function automatic int ancho_cnt(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rebote_bit.sv
// rtl/rebote_bit.sv - one button: 2-flop synchronizer, tick-paced debounce, edge/change flags
module rebote_bit
  import lab_pkg::*;
#(
  parameter int STABLE = STABLE_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic btn,
  output logic nivel,
  output logic flanco,
  output logic cambio
);

  localparam int CW = ancho_cnt(STABLE);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE - 1);

  logic          s1;
  logic          s;
  logic [CW-1:0] cnt;
  logic          acepta;

  // The tick on which a disagreeing level has persisted long enough to be taken.
  assign acepta = tick && (s != nivel) && (cnt == CNT_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      s1     <= 1'b0;
      s      <= 1'b0;
      cnt    <= '0;
      nivel  <= 1'b0;
      flanco <= 1'b0;
      cambio <= 1'b0;
    end else begin
      s1     <= btn;
      s      <= s1;
      flanco <= acepta && s;
      cambio <= acepta;
      if (tick) begin
        if (s == nivel) begin
          cnt <= '0;
        end else if (cnt == CNT_MAX) begin
          nivel <= s;
          cnt   <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/rebote_ocho_botones.sv
// rtl/rebote_ocho_botones.sv - eight-button debouncer with shared prescaler and press/change strobes
module rebote_ocho_botones
  import lab_pkg::*;
#(
  parameter int DIV    = DIV_DEF,
  parameter int STABLE = STABLE_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_BOTONES-1:0] btn,
  output logic [N_BOTONES-1:0] ocho,
  output logic [N_BOTONES-1:0] flanco,
  output logic                 cambio
);

  localparam int PW = ancho_cnt(DIV);
  localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);

  logic [PW-1:0]        pre;
  logic                 tick;
  logic [N_BOTONES-1:0] cambio_bit;

  // Free-running; input activity never restarts the sampling phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      pre <= '0;
    end else if (pre == PRE_MAX) begin
      pre <= '0;
    end else begin
      pre <= pre + PW'(1);
    end
  end

  assign tick = (pre == PRE_MAX);

  for (genvar i = 0; i < N_BOTONES; i++) begin : g_bit
    rebote_bit #(
      .STABLE(STABLE)
    ) u_bit (
      .clk   (clk),
      .rst   (rst),
      .tick  (tick),
      .btn   (btn[i]),
      .nivel (ocho[i]),
      .flanco(flanco[i]),
      .cambio(cambio_bit[i])
    );
  end

  assign cambio = |cambio_bit;

endmodule

// File: tb/tb_rebote_ocho_botones.sv
// tb/tb_rebote_ocho_botones.sv - directed self-checking bench for rebote_ocho_botones (DIV=4, STABLE=3)
module tb_rebote_ocho_botones;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] btn;
  logic [7:0] ocho;
  logic [7:0] flanco;
  logic       cambio;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] modelo;

  rebote_ocho_botones #(
    .DIV   (4),
    .STABLE(3)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn),
    .ocho  (ocho),
    .flanco(flanco),
    .cambio(cambio)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] esp);
    checks++;
    if (obs !== esp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, esp);
    end
  endtask

  task automatic paso();
    @(posedge clk);
    #1;
  endtask

  // Waits for ocho to leave the model value; the update must land 11..14 edges after btn changed.
  task automatic esperar_cambio(input logic [7:0] nuevo, input logic [7:0] flanco_esp, input string tag);
    int k;
    k = 0;
    for (int c = 1; c <= 20; c++) begin
      paso();
      if (ocho !== modelo) begin
        k = c;
        break;
      end
      check({tag, "_quiet"}, 32'({flanco, cambio}), 32'd0);
    end
    check({tag, "_latency_in_11_14"}, 32'((k >= 11) && (k <= 14)), 32'd1);
    check({tag, "_ocho"}, 32'(ocho), 32'(nuevo));
    check({tag, "_flanco"}, 32'(flanco), 32'(flanco_esp));
    check({tag, "_cambio"}, 32'(cambio), 32'd1);
    paso();
    check({tag, "_after_strobes"}, 32'({flanco, cambio}), 32'd0);
    check({tag, "_after_ocho"}, 32'(ocho), 32'(nuevo));
    modelo = nuevo;
  endtask

  // After a one-edge reset with btn already at target, acceptance lands exactly on edge 12.
  task automatic tras_reset(input logic [7:0] nuevo, input string tag);
    for (int k = 1; k <= 11; k++) begin
      paso();
      check({tag, "_hold"}, 32'({ocho, flanco, cambio}), 32'd0);
    end
    paso();
    check({tag, "_ocho"}, 32'(ocho), 32'(nuevo));
    check({tag, "_flanco"}, 32'(flanco), 32'(nuevo));
    check({tag, "_cambio"}, 32'(cambio), 32'd1);
    paso();
    check({tag, "_after"}, 32'({ocho, flanco, cambio}), 32'({nuevo, 8'h00, 1'b0}));
    modelo = nuevo;
  endtask

  initial begin
    rst    = 1'b1;
    btn    = 8'hFF;
    modelo = 8'h00;

    for (int k = 0; k < 3; k++) begin
      paso();
      check("reset_outputs", 32'({ocho, flanco, cambio}), 32'd0);
    end
    rst = 1'b0;
    tras_reset(8'hFF, "reset_release");

    btn = 8'h00;
    esperar_cambio(8'h00, 8'h00, "release_all");

    btn = 8'h01;
    esperar_cambio(8'h01, 8'h01, "single_press");
    for (int k = 0; k < 5; k++) begin
      paso();
      check("single_hold", 32'({ocho, flanco, cambio}), 32'({8'h01, 8'h00, 1'b0}));
    end
    btn = 8'h00;
    esperar_cambio(8'h00, 8'h00, "single_release");

    btn = 8'h08;
    for (int k = 0; k < 6; k++) begin
      paso();
      check("glitch_high", 32'({ocho, flanco, cambio}), 32'd0);
    end
    btn = 8'h00;
    for (int k = 0; k < 24; k++) begin
      paso();
      check("glitch_after", 32'({ocho, flanco, cambio}), 32'd0);
    end

    btn = 8'h48;
    esperar_cambio(8'h48, 8'h48, "simul_press");
    btn = 8'h00;
    esperar_cambio(8'h00, 8'h00, "simul_release");

    rst = 1'b1;
    paso();
    rst = 1'b0;
    btn = 8'h40;
    for (int k = 0; k < 8; k++) begin
      paso();
      check("midcount_pre", 32'({ocho, flanco, cambio}), 32'd0);
    end
    rst = 1'b1;
    paso();
    check("midcount_in_reset", 32'({ocho, flanco, cambio}), 32'd0);
    rst = 1'b0;
    tras_reset(8'h40, "midcount_fresh");
    btn = 8'h00;
    esperar_cambio(8'h00, 8'h00, "midcount_release");

    btn = 8'hFF;
    esperar_cambio(8'hFF, 8'hFF, "all_press");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
